sad_min_select: RTL and testbench
=================================

Name: sad_min_select

Overview:
- Consumes per-candidate SADs for all 41 H.264 partitions (4x4 up to 16x16) from the SAD adder-tree stage, one candidate position per valid beat.
- Tracks the minimum SAD and its motion vector per partition across one macroblock's search window.
- Presents the 41 winning (SAD, MV) pairs to mode decision through a valid/ready handshake.

Parameters:
- SAD_WIDTH, 16, width of every SAD value and best-SAD register (16x16x255 = 65280 fits).
- MV_WIDTH, 8, signed two's-complement width of each MV component.
- NUM_PART, 41, number of partitions; fixed by the package constant and not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins a new macroblock search; accepted only in IDLE
- in_valid  in  1  sad_in, mv_x, mv_y and in_last hold a candidate
- in_ready  out  1  block can accept a candidate
- in_last  in  1  marks the final candidate of the search
- sad_in  in  NUM_PART x SAD_WIDTH  candidate SADs, indexed per package
- mv_x, mv_y  in  MV_WIDTH each  signed candidate displacement
- out_valid  out  1  results are stable
- out_ready  in  1  consumer accepts the results
- best_sad  out  NUM_PART x SAD_WIDTH  minimum cost per partition
- best_mvx, best_mvy  out  NUM_PART x MV_WIDTH each  MV of the winner per partition

Behaviour:
- Reset values: all outputs 0, including in_ready and out_valid; FSM state IDLE. Reset mid-search aborts the search, discards partial minima and forces IDLE on the next edge.
- FSM states: IDLE, SEARCH, HOLD.
  - IDLE: in_ready = 0. start moves to SEARCH and sets the first_flag.
  - SEARCH: in_ready = 1. A beat is accepted when in_valid and in_ready are both 1.
  - An accepted beat with in_last = 1 moves to HOLD.
  - HOLD: in_ready = 0, out_valid = 1. out_valid and out_ready both 1 moves to IDLE.
  - start outside IDLE is ignored.
- Per accepted beat, for each partition p, compute cost[p] (equals sad_in[p] without the option).
  - If first_flag is set, load cost[p], mv_x and mv_y unconditionally.
  - Otherwise update only if cost[p] < best_sad[p]. Strict less-than, so on a tie the earlier candidate wins.
  - first_flag clears after the first accepted beat.
- Registered update: one-cycle latency. The last beat's update is visible together with out_valid = 1 on the cycle after acceptance.
- A single-candidate search (first beat has in_last = 1) is legal; results equal that candidate.
- Outputs stay stable and registered while in HOLD; they are not cleared on return to IDLE.
- in_valid while in IDLE or HOLD is ignored and not consumed.
- start and in_valid in the same cycle: only start is taken (in_ready was 0).
- Comparison is unsigned on SAD_WIDTH bits; there are no internal widths wider than SAD_WIDTH except cost computation.

Optional Feature:
- Macro: SAD_MV_COST_EN.
- Defined:
  - Adds input lambda (6 bits, unsigned) to the port list.
  - cost[p] = sad_in[p] + lambda * (|mv_x| + |mv_y|), computed at SAD_WIDTH+8 bits and saturated to all-ones SAD_WIDTH.
  - best_sad reports the cost, not the raw SAD.
  - |-2^(MV_WIDTH-1)| is taken as 2^(MV_WIDTH-1).
- Undefined: no lambda port; cost = sad_in with no added logic.

Decomposition:
- Package sad_pkg holds:
  - NUM_PART = 41.
  - Partition index constants: 0-15 4x4 raster (row*4+col), 16-23 4x8, 24-31 8x4, 32-35 8x8, 36-37 16x8, 38-39 8x16, 40 16x16.
  - FSM state enum typedef.
  - sad_t and mv_t typedefs.
- Sub-module sad_min_cell: one partition's cost compare and best-SAD/MV registers, with load/first inputs. It is instantiated NUM_PART times in a generate loop. The FSM and handshake stay in the top module.

Test Plan:
- Search of 3 candidates, partition 40 SADs 500, 300, 400 with MVs (1,1), (-2,3), (4,0) -> best_sad[40]=300, mv (-2,3). out_valid is 1 on the cycle after the third beat is accepted.
- Tie: candidates with sad 200 at mv (0,0) then sad 200 at mv (5,5) -> mv (0,0) retained.
- Single beat with in_last=1, all sad=65535 and mv (-128,127) -> every output equals it. Hold out_ready=0 for 10 cycles -> out_valid and data remain stable and in_ready stays 0.
- Assert rst after 2 of 4 beats, then start a new search of one beat with sad=7 -> results reflect only sad=7, and every output reads 0 between reset and start.
- With SAD_MV_COST_EN, lambda=4: sad 100 at mv (0,0) vs sad 90 at mv (2,1) -> costs 100 vs 102, winner (0,0) with best_sad 100. sad 65530 at mv (3,3) alone -> best_sad 65535 (saturated).
- in_valid toggling randomly with gaps and start pulses during SEARCH -> only handshaken beats counted; start is ignored.

Source files
------------

// File: rtl/sad_min_select_pkg.sv
// Shared constants and types for the per-partition minimum-SAD selector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sad_pkg;

   localparam int NUM_PART = 41;
   localparam int SAD_W    = 16;
   localparam int MV_W     = 8;

   // Partition index map inside the sad_in / best_* vectors
   localparam int P4X4_BASE  = 0;   // 16 entries, raster order row*4+col
   localparam int P4X8_BASE  = 16;  // 8 entries
   localparam int P8X4_BASE  = 24;  // 8 entries
   localparam int P8X8_BASE  = 32;  // 4 entries
   localparam int P16X8_BASE = 36;  // 2 entries
   localparam int P8X16_BASE = 38;  // 2 entries
   localparam int P16X16     = 40;  // 1 entry

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      HOLD   = 2'd2
   } state_t;

   typedef logic [SAD_W-1:0]       sad_t;
   typedef logic signed [MV_W-1:0] mv_t;

endpackage

// File: rtl/sad_min_select_cell.sv
// One partition's running minimum: cost compare plus best cost/MV registers.
// Latency: the update is registered, visible one cycle after load.
// Backpressure: none; load is qualified by the parent handshake. Optional MV cost term under SAD_MV_COST_EN.
module sad_min_cell
   import sad_pkg::*;
#(
   parameter int SAD_WIDTH = SAD_W,
   parameter int MV_WIDTH  = MV_W
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 first,
   input  logic [SAD_WIDTH-1:0] sad_in,
   input  logic [MV_WIDTH-1:0]  mv_x,
   input  logic [MV_WIDTH-1:0]  mv_y,
`ifdef SAD_MV_COST_EN
   input  logic [5:0]           lambda,
`endif
   output logic [SAD_WIDTH-1:0] best_sad,
   output logic [MV_WIDTH-1:0]  best_mvx,
   output logic [MV_WIDTH-1:0]  best_mvy
);

   logic [SAD_WIDTH-1:0] cost;

`ifdef SAD_MV_COST_EN
   localparam int CW = SAD_WIDTH + 8;

   logic [MV_WIDTH:0] abs_x;
   logic [MV_WIDTH:0] abs_y;
   logic [CW-1:0]     cost_wide;

   // sad + lambda*(|mvx|+|mvy|); one extra magnitude bit so the most negative MV maps to +2^(MV_WIDTH-1)
   always_comb begin
      abs_x = {1'b0, mv_x};
      abs_y = {1'b0, mv_y};
      if (mv_x[MV_WIDTH-1]) abs_x = (MV_WIDTH+1)'(0) - {1'b1, mv_x};
      if (mv_y[MV_WIDTH-1]) abs_y = (MV_WIDTH+1)'(0) - {1'b1, mv_y};
      cost_wide = CW'(sad_in) + CW'(lambda) * (CW'(abs_x) + CW'(abs_y));
      cost = (cost_wide > CW'({SAD_WIDTH{1'b1}})) ? {SAD_WIDTH{1'b1}} : cost_wide[SAD_WIDTH-1:0];
   end
`else
   // Cost is the raw SAD
   always_comb begin
      cost = sad_in;
   end
`endif

   // Keep the earliest strict minimum; the first beat of a search loads unconditionally
   always_ff @(posedge clk) begin
      if (rst) begin
         best_sad <= '0;
         best_mvx <= '0;
         best_mvy <= '0;
      end else if (load && (first || (cost < best_sad))) begin
         best_sad <= cost;
         best_mvx <= mv_x;
         best_mvy <= mv_y;
      end
   end

endmodule

// File: rtl/sad_min_select.sv
// Tracks min cost and MV for all 41 partitions over one macroblock search window.
// Latency: one cycle from last accepted beat to out_valid with final results.
// Backpressure: in_ready only in SEARCH; results held in HOLD until out_ready. Optional macro: SAD_MV_COST_EN.
module sad_min_select
   import sad_pkg::*;
#(
   parameter int SAD_WIDTH = SAD_W,
   parameter int MV_WIDTH  = MV_W
)(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic                               in_last,
   input  logic [NUM_PART-1:0][SAD_WIDTH-1:0] sad_in,
   input  logic [MV_WIDTH-1:0]                mv_x,
   input  logic [MV_WIDTH-1:0]                mv_y,
`ifdef SAD_MV_COST_EN
   input  logic [5:0]                         lambda,
`endif
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [NUM_PART-1:0][SAD_WIDTH-1:0] best_sad,
   output logic [NUM_PART-1:0][MV_WIDTH-1:0]  best_mvx,
   output logic [NUM_PART-1:0][MV_WIDTH-1:0]  best_mvy
);

   state_t state;
   logic   first_flag;
   logic   accept;

   assign accept = in_valid & in_ready;

   // Search control: IDLE -> SEARCH on start, SEARCH -> HOLD on last beat, HOLD -> IDLE on consumer accept
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         first_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SEARCH;
                  in_ready   <= 1'b1;
                  first_flag <= 1'b1;
               end
            end
            SEARCH: begin
               if (accept) begin
                  first_flag <= 1'b0;
                  if (in_last) begin
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   for (genvar p = 0; p < NUM_PART; p++) begin : g_cell
      sad_min_cell #(
         .SAD_WIDTH (SAD_WIDTH),
         .MV_WIDTH  (MV_WIDTH)
      ) u_cell (
         .clk      (clk),
         .rst      (rst),
         .load     (accept),
         .first    (first_flag),
         .sad_in   (sad_in[p]),
         .mv_x     (mv_x),
         .mv_y     (mv_y),
`ifdef SAD_MV_COST_EN
         .lambda   (lambda),
`endif
         .best_sad (best_sad[p]),
         .best_mvx (best_mvx[p]),
         .best_mvy (best_mvy[p])
      );
   end

endmodule

// File: tb/tb_sad_min_select.sv
// Bench for sad_min_select: directed scenarios plus randomized searches against a list-based reference.
// Latency: checks out_valid and results on the cycle after the last accepted beat.
// Backpressure: exercises in_valid gaps, stray start pulses and delayed out_ready.
module tb_sad_min_select;
   import sad_pkg::*;

   localparam int NP = NUM_PART;

   typedef logic [NP-1:0][15:0] sadv_t;
   typedef logic [NP-1:0][7:0]  mvv_t;
   typedef struct packed {
      sadv_t      cost;
      logic [7:0] mx;
      logic [7:0] my;
   } cand_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic       in_last;
   sadv_t      sad_in;
   logic [7:0] mv_x;
   logic [7:0] mv_y;
   logic       out_valid;
   logic       out_ready;
   sadv_t      best_sad;
   mvv_t       best_mvx;
   mvv_t       best_mvy;
`ifdef SAD_MV_COST_EN
   logic [5:0] lambda;
`endif

   always #5 clk = ~clk;

   sad_min_select dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .sad_in    (sad_in),
      .mv_x      (mv_x),
      .mv_y      (mv_y),
`ifdef SAD_MV_COST_EN
      .lambda    (lambda),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .best_sad  (best_sad),
      .best_mvx  (best_mvx),
      .best_mvy  (best_mvy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   cand_t      cands[$];
   sadv_t      pl_sad[$];
   logic [7:0] pl_mx[$];
   logic [7:0] pl_my[$];
   sadv_t      nxt_sad;
   logic [7:0] nxt_mx;
   logic [7:0] nxt_my;
   sadv_t      exp_sad;
   mvv_t       exp_mvx;
   mvv_t       exp_mvy;

   function automatic sadv_t rand_sadv(int unsigned hi);
      sadv_t v;
      for (int p = 0; p < NP; p++) v[p] = 16'($urandom_range(0, hi));
      return v;
   endfunction

   function automatic sadv_t fill_sadv(logic [15:0] val);
      sadv_t v;
      for (int p = 0; p < NP; p++) v[p] = val;
      return v;
   endfunction

   // Cost of the candidate currently on the inputs, from plain integer arithmetic
   function automatic sadv_t cost_now();
      sadv_t c;
`ifdef SAD_MV_COST_EN
      int sx, sy, w;
      sx = int'($signed(mv_x));
      sy = int'($signed(mv_y));
      if (sx < 0) sx = -sx;
      if (sy < 0) sy = -sy;
      for (int p = 0; p < NP; p++) begin
         w = int'(sad_in[p]) + int'(lambda) * (sx + sy);
         c[p] = (w > 65535) ? 16'hFFFF : 16'(w);
      end
`else
      c = sad_in;
`endif
      return c;
   endfunction

   // Reference: per partition, the first candidate holding the minimum cost in the accepted list
   task automatic compute_expected();
      int bi;
      for (int p = 0; p < NP; p++) begin
         bi = 0;
         for (int i = 1; i < cands.size(); i++)
            if (cands[i].cost[p] < cands[bi].cost[p]) bi = i;
         exp_sad[p] = cands[bi].cost[p];
         exp_mvx[p] = cands[bi].mx;
         exp_mvy[p] = cands[bi].my;
      end
   endtask

   task automatic plan_clear();
      pl_sad.delete();
      pl_mx.delete();
      pl_my.delete();
   endtask

   task automatic plan_add(input sadv_t s, input logic [7:0] mx, input logic [7:0] my);
      pl_sad.push_back(s);
      pl_mx.push_back(mx);
      pl_my.push_back(my);
   endtask

   // Offer nxt_* until handshaken; optional idle gaps and stray start pulses
   task automatic send_beat(input bit last, input bit gaps, input bit rstart);
      int    budget;
      bit    done;
      cand_t c;
      budget = 100;
      done   = 1'b0;
      while (!done && budget > 0) begin
         budget--;
         start = rstart && ($urandom_range(0, 3) == 0);
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            sad_in   = rand_sadv(65535);
            mv_x     = 8'($urandom);
            mv_y     = 8'($urandom);
         end else begin
            in_valid = 1'b1;
            in_last  = last;
            sad_in   = nxt_sad;
            mv_x     = nxt_mx;
            mv_y     = nxt_my;
            if (in_ready === 1'b1) begin
               c.cost = cost_now();
               c.mx   = nxt_mx;
               c.my   = nxt_my;
               cands.push_back(c);
               done = 1'b1;
            end
         end
         @(negedge clk);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL beat_handshake: in_ready=%b, required 1 within budget", in_ready);
      end
   endtask

   // Start a search (with ignored valid noise in IDLE) and send the whole plan
   task automatic do_search(input bit gaps, input bit rstart);
      cands.delete();
      in_valid = 1'b1;
      in_last  = 1'b1;
      sad_in   = rand_sadv(3);
      mv_x     = 8'($urandom);
      mv_y     = 8'($urandom);
      @(negedge clk);
      start  = 1'b1;
      sad_in = rand_sadv(3);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int i = 0; i < pl_sad.size(); i++) begin
         nxt_sad = pl_sad[i];
         nxt_mx  = pl_mx[i];
         nxt_my  = pl_my[i];
         send_beat(i == pl_sad.size() - 1, gaps, rstart);
      end
      compute_expected();
   endtask

   task automatic release_results(input int hold);
      out_ready = 1'b0;
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (best_sad !== '0)    begin n_fail++; $display("FAIL reset_best_sad: got %h want 0", best_sad); end
      n_checks++; if (best_mvx !== '0)    begin n_fail++; $display("FAIL reset_best_mvx: got %h want 0", best_mvx); end
      n_checks++; if (best_mvy !== '0)    begin n_fail++; $display("FAIL reset_best_mvy: got %h want 0", best_mvy); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_three();
      sadv_t s;
      plan_clear();
      s = rand_sadv(65535); s[P16X16] = 16'd500; plan_add(s, 8'sd1, 8'sd1);
      s = rand_sadv(65535); s[P16X16] = 16'd300; plan_add(s, -8'sd2, 8'sd3);
      s = rand_sadv(65535); s[P16X16] = 16'd400; plan_add(s, 8'sd4, 8'sd0);
      do_search(1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL three_out_valid: got %b want 1", out_valid); end
      n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL three_in_ready: got %b want 0", in_ready); end
      n_checks++; if (best_sad[P16X16] !== 16'd300) begin n_fail++; $display("FAIL three_p40_sad: got %0d want 300", best_sad[P16X16]); end
      n_checks++; if (best_mvx[P16X16] !== 8'hFE || best_mvy[P16X16] !== 8'h03)
         begin n_fail++; $display("FAIL three_p40_mv: got (%h,%h) want (fe,03)", best_mvx[P16X16], best_mvy[P16X16]); end
      n_checks++; if (best_sad !== exp_sad) begin n_fail++; $display("FAIL three_sad: got %h want %h", best_sad, exp_sad); end
      n_checks++; if (best_mvx !== exp_mvx) begin n_fail++; $display("FAIL three_mvx: got %h want %h", best_mvx, exp_mvx); end
      n_checks++; if (best_mvy !== exp_mvy) begin n_fail++; $display("FAIL three_mvy: got %h want %h", best_mvy, exp_mvy); end
      release_results(0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL three_release: got %b want 0", out_valid); end
   endtask

   task automatic test_tie();
      plan_clear();
      plan_add(fill_sadv(16'd200), 8'd0, 8'd0);
      plan_add(fill_sadv(16'd200), 8'd5, 8'd5);
      do_search(1'b0, 1'b0);
      n_checks++; if (best_sad !== fill_sadv(16'd200)) begin n_fail++; $display("FAIL tie_sad: got %h want all 00c8", best_sad); end
      n_checks++; if (best_mvx !== '0 || best_mvy !== '0)
         begin n_fail++; $display("FAIL tie_mv: got %h/%h want all zero", best_mvx, best_mvy); end
      release_results(1);
   endtask

   task automatic test_single_hold();
      mvv_t want_x, want_y;
      for (int p = 0; p < NP; p++) begin
         want_x[p] = 8'h80;
         want_y[p] = 8'h7F;
      end
      plan_clear();
      plan_add(fill_sadv(16'hFFFF), 8'h80, 8'h7F);
      do_search(1'b0, 1'b0);
      n_checks++; if (best_sad !== fill_sadv(16'hFFFF) || best_mvx !== want_x || best_mvy !== want_y)
         begin n_fail++; $display("FAIL single_data: got sad %h mvx %h mvy %h", best_sad, best_mvx, best_mvy); end
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         start    = 1'($urandom_range(0, 1));
         sad_in   = rand_sadv(3);
         @(negedge clk);
         n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            begin n_fail++; $display("FAIL hold_flags: cycle %0d got out_valid %b in_ready %b want 1 0", c, out_valid, in_ready); end
         n_checks++; if (best_sad !== fill_sadv(16'hFFFF) || best_mvx !== want_x || best_mvy !== want_y)
            begin n_fail++; $display("FAIL hold_data: cycle %0d got sad %h", c, best_sad); end
      end
      in_valid = 1'b0;
      start    = 1'b0;
      release_results(0);
      n_checks++; if (out_valid !== 1'b0 || best_sad !== fill_sadv(16'hFFFF))
         begin n_fail++; $display("FAIL single_after_release: got out_valid %b sad %h", out_valid, best_sad); end
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         nxt_sad = rand_sadv(65535);
         nxt_mx  = 8'($urandom);
         nxt_my  = 8'($urandom);
         send_beat(1'b0, 1'b0, 1'b0);
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
         begin n_fail++; $display("FAIL midrst_flags: got in_ready %b out_valid %b want 0 0", in_ready, out_valid); end
      n_checks++; if (best_sad !== '0 || best_mvx !== '0 || best_mvy !== '0)
         begin n_fail++; $display("FAIL midrst_data: got sad %h", best_sad); end
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         sad_in   = rand_sadv(3);
         @(negedge clk);
         n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || best_sad !== '0 || best_mvx !== '0 || best_mvy !== '0)
            begin n_fail++; $display("FAIL midrst_idle: cycle %0d got in_ready %b out_valid %b sad %h", c, in_ready, out_valid, best_sad); end
      end
      in_valid = 1'b0;
      plan_clear();
      plan_add(fill_sadv(16'd7), 8'($urandom), 8'($urandom));
      do_search(1'b0, 1'b0);
      n_checks++; if (best_sad !== fill_sadv(16'd7)) begin n_fail++; $display("FAIL midrst_sad7: got %h want all 0007", best_sad); end
      n_checks++; if (best_mvx !== exp_mvx || best_mvy !== exp_mvy)
         begin n_fail++; $display("FAIL midrst_mv: got %h/%h want %h/%h", best_mvx, best_mvy, exp_mvx, exp_mvy); end
      release_results(0);
   endtask

`ifdef SAD_MV_COST_EN
   task automatic test_cost();
      lambda = 6'd4;
      plan_clear();
      plan_add(fill_sadv(16'd100), 8'd0, 8'd0);
      plan_add(fill_sadv(16'd90), 8'd2, 8'd1);
      do_search(1'b0, 1'b0);
      n_checks++; if (best_sad !== fill_sadv(16'd100) || best_mvx !== '0 || best_mvy !== '0)
         begin n_fail++; $display("FAIL cost_winner: got sad %h mvx %h", best_sad, best_mvx); end
      release_results(0);
      plan_clear();
      plan_add(fill_sadv(16'd65530), 8'd3, 8'd3);
      do_search(1'b0, 1'b0);
      n_checks++; if (best_sad !== fill_sadv(16'hFFFF)) begin n_fail++; $display("FAIL cost_saturate: got %h want all ffff", best_sad); end
      release_results(0);
      lambda = 6'd0;
   endtask
`endif

   task automatic test_random();
      int n, mode;
      for (int s = 0; s < 12; s++) begin
         n    = $urandom_range(1, 8);
         mode = $urandom_range(0, 2);
`ifdef SAD_MV_COST_EN
         lambda = 6'($urandom_range(0, 63));
`endif
         plan_clear();
         for (int i = 0; i < n; i++)
            plan_add(rand_sadv(mode == 0 ? 65535 : (mode == 1 ? 3 : 1000)), 8'($urandom), 8'($urandom));
         do_search(1'b1, 1'b1);
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_out_valid: search %0d got %b want 1", s, out_valid); end
         n_checks++; if (best_sad !== exp_sad) begin n_fail++; $display("FAIL rand_sad: search %0d got %h want %h", s, best_sad, exp_sad); end
         n_checks++; if (best_mvx !== exp_mvx || best_mvy !== exp_mvy)
            begin n_fail++; $display("FAIL rand_mv: search %0d got %h/%h want %h/%h", s, best_mvx, best_mvy, exp_mvx, exp_mvy); end
         release_results($urandom_range(0, 3));
         n_checks++; if (out_valid !== 1'b0 || best_sad !== exp_sad)
            begin n_fail++; $display("FAIL rand_release: search %0d got out_valid %b", s, out_valid); end
      end
`ifdef SAD_MV_COST_EN
      lambda = 6'd0;
`endif
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      sad_in    = '0;
      mv_x      = '0;
      mv_y      = '0;
      out_ready = 1'b0;
`ifdef SAD_MV_COST_EN
      lambda    = 6'd0;
`endif
      @(negedge clk);
      test_reset();
      test_three();
      test_tie();
      test_single_hold();
      test_reset_mid();
`ifdef SAD_MV_COST_EN
      test_cost();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
